// File: rtl/inst_mem_burst_responder.sv
// Purpose: answers an instruction-cache line fill by reading one block from a
//          synchronous instruction BRAM (offset 0 first) and streaming it back.
// Latency: first word BRAM_LATENCY+1 cycles after the request edge; words are
//          GAP_CYCLES+1 cycles apart.
// Backpressure: none on the return side; the requester holds mem_enable for the
//               whole burst, and dropping it aborts the burst and flushes the pipe.
// Ports: clk/rst (async, active-high); mem_addr/mem_enable fill request;
//        mem_read/mem_read_valid/mem_last word stream; busy = not IDLE;
//        bram_en/bram_addr/bram_dout BRAM read port.
module inst_mem_burst_responder #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 16,
  parameter int BLOCK_OFFSET_WIDTH = 5,
  parameter int BRAM_LATENCY       = 1,
  parameter int GAP_CYCLES         = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_enable,
  output logic [DATA_WIDTH-1:0] mem_read,
  output logic                  mem_read_valid,
  output logic                  mem_last,
  output logic                  busy,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  localparam int BLOCK_SIZE = 1 << BLOCK_OFFSET_WIDTH;
  localparam int CW         = BLOCK_OFFSET_WIDTH + 1;
  localparam int GW         = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [CW-1:0]         LAST_K   = CW'(BLOCK_SIZE - 1);
  localparam logic [GW-1:0]         GAP_INIT = GW'(GAP_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   base;
  logic [CW-1:0]           issue_cnt;   // index of the next word to issue
  logic [GW-1:0]           gap_cnt;
  logic                    issue_last;  // travels with bram_en, marks offset BLOCK_SIZE-1
  logic [BRAM_LATENCY-1:0] pipe_vld;
  logic [BRAM_LATENCY-1:0] pipe_last;

  logic                  do_issue;
  logic                  abort;
  logic [CW-1:0]         issue_k;
  logic [ADDR_WIDTH-1:0] issue_base;

  assign mem_read_valid = pipe_vld[BRAM_LATENCY-1];
  assign mem_last       = pipe_last[BRAM_LATENCY-1];
  assign mem_read       = mem_read_valid ? bram_dout : '0;
  assign busy           = (state != IDLE);
  assign abort          = (state != IDLE) && !mem_enable;

  // Word 0 is issued on the accepting edge itself, so the block base comes
  // straight from mem_addr in IDLE and from the latched copy afterwards.
  always_comb begin
    next_state = state;
    do_issue   = 1'b0;
    issue_k    = issue_cnt;
    issue_base = base;
    case (state)
      IDLE: begin
        issue_base = mem_addr & ~OFF_MASK;
        issue_k    = '0;
        if (mem_enable) begin
          do_issue   = 1'b1;
          next_state = (BLOCK_SIZE == 1) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (!mem_enable) begin
          next_state = IDLE;
        end else if (gap_cnt == '0) begin
          do_issue = 1'b1;
          if (issue_cnt == LAST_K) next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (!mem_enable || mem_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      issue_cnt  <= '0;
      gap_cnt    <= '0;
      issue_last <= 1'b0;
      bram_en    <= 1'b0;
      bram_addr  <= '0;
      pipe_vld   <= '0;
      pipe_last  <= '0;
    end else begin
      state      <= next_state;
      bram_en    <= do_issue;
      issue_last <= do_issue && (issue_k == LAST_K);

      if (do_issue) begin
        // base has zero offset bits and issue_k < BLOCK_SIZE, so no carry
        // ever reaches the block index bits.
        bram_addr <= issue_base + ADDR_WIDTH'(issue_k);
        issue_cnt <= issue_k + CW'(1);
        gap_cnt   <= GAP_INIT;
        if (state == IDLE) base <= issue_base;
      end else if (state == ISSUE && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end

      // Flags ride alongside the BRAM read so they surface with bram_dout.
      if (abort) begin
        pipe_vld  <= '0;
        pipe_last <= '0;
      end else begin
        pipe_vld[0]  <= bram_en;
        pipe_last[0] <= issue_last;
        for (int i = 1; i < BRAM_LATENCY; i++) begin
          pipe_vld[i]  <= pipe_vld[i-1];
          pipe_last[i] <= pipe_last[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_burst_responder.sv
module tb_inst_mem_burst_responder;

  logic        clk;
  logic        rst;

  // dut0: GAP_CYCLES=0, BRAM_LATENCY=1
  logic [15:0] addr0;
  logic        en0;
  logic [31:0] rd0;
  logic        vld0, last0, busy0, ben0;
  logic [15:0] baddr0;
  logic [31:0] dout0;

  // dut1: GAP_CYCLES=2, BRAM_LATENCY=2
  logic [15:0] addr1;
  logic        en1;
  logic [31:0] rd1;
  logic        vld1, last1, busy1, ben1;
  logic [15:0] baddr1;
  logic [31:0] dout1;
  logic [31:0] stage1;

  int errors = 0;
  int checks = 0;

  inst_mem_burst_responder dut0 (
    .clk(clk), .rst(rst), .mem_addr(addr0), .mem_enable(en0),
    .mem_read(rd0), .mem_read_valid(vld0), .mem_last(last0), .busy(busy0),
    .bram_en(ben0), .bram_addr(baddr0), .bram_dout(dout0)
  );

  inst_mem_burst_responder #(.GAP_CYCLES(2), .BRAM_LATENCY(2)) dut1 (
    .clk(clk), .rst(rst), .mem_addr(addr1), .mem_enable(en1),
    .mem_read(rd1), .mem_read_valid(vld1), .mem_last(last1), .busy(busy1),
    .bram_en(ben1), .bram_addr(baddr1), .bram_dout(dout1)
  );

  function automatic logic [31:0] word_of(input logic [15:0] a);
    return {16'h0000, a} ^ 32'hA5A50000;
  endfunction

  // BRAM models: contents are a ^ 32'hA5A50000
  always @(posedge clk) begin
    if (ben0) dout0 <= word_of(baddr0);
    if (ben1) stage1 <= word_of(baddr1);
    dout1 <= stage1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sample(input bit sel, output logic v, output logic l, output logic b,
                        output logic be, output logic [15:0] ba, output logic [31:0] rd);
    if (sel) begin
      v = vld1; l = last1; b = busy1; be = ben1; ba = baddr1; rd = rd1;
    end else begin
      v = vld0; l = last0; b = busy0; be = ben0; ba = baddr0; rd = rd0;
    end
  endtask

  // Requests a fill (enable left high on return, in the first IDLE cycle)
  // and checks every returned word against the expected block.
  task automatic run_fill(input bit sel, input logic [15:0] addr, input logic [15:0] exp_base,
                          input int exp_first, input int exp_space,
                          output int nv, output int nl);
    logic v, l, b, be;
    logic [15:0] ba;
    logic [31:0] rd;
    int cyc, prev, n;
    bit done;
    if (sel) begin en1 = 1'b1; addr1 = addr; end
    else     begin en0 = 1'b1; addr0 = addr; end
    cyc = 0; prev = 0; n = 0; nl = 0; done = 0;
    while (!done) begin
      tick();
      cyc++;
      sample(sel, v, l, b, be, ba, rd);
      if (cyc == 1) begin
        chk("first_bram_en", {31'd0, be}, 32'd1);
        chk("first_bram_addr", {16'd0, ba}, {16'd0, exp_base});
      end
      if (v) begin
        if (n == 0) chk("first_latency", cyc, exp_first);
        else        chk("valid_spacing", cyc - prev, exp_space);
        chk("word_data", rd, word_of(exp_base + 16'(n)));
        chk("last_flag", {31'd0, l}, {31'd0, (n == 31)});
        prev = cyc;
        n++;
        if (l) begin nl++; done = 1; end
      end else begin
        chk("quiet_outputs", {l, rd[30:0]} | {31'd0, rd[31]}, 32'd0);
      end
      if (cyc >= 400) begin
        errors++; checks++;
        $display("FAIL burst_timeout: got %0d words expected 32", n);
        done = 1;
      end
    end
    chk("last_valid_cycle", prev, exp_first + 31 * exp_space);
    nv = n;
    tick();
    sample(sel, v, l, b, be, ba, rd);
    chk("busy_after_burst", {31'd0, b}, 32'd0);
  endtask

  typedef struct {
    bit          sel;
    logic [15:0] addr;
    logic [15:0] base;
    int          first;
    int          space;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int nv, nl, nv2, nl2, n, cnt;

    vecs[0] = '{sel: 1'b0, addr: 16'h1234, base: 16'h1220, first: 2, space: 1};
    vecs[1] = '{sel: 1'b0, addr: 16'hFFFF, base: 16'hFFE0, first: 2, space: 1};
    vecs[2] = '{sel: 1'b0, addr: 16'h0005, base: 16'h0000, first: 2, space: 1};
    vecs[3] = '{sel: 1'b1, addr: 16'h1234, base: 16'h1220, first: 3, space: 3};

    rst = 1'b1; en0 = 1'b0; en1 = 1'b0; addr0 = 'x; addr1 = 'x;
    repeat (2) tick();
    chk("rst_valid", {31'd0, vld0}, 32'd0);
    chk("rst_last", {31'd0, last0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_bram_en", {31'd0, ben0}, 32'd0);
    chk("rst_bram_addr", {16'd0, baddr0}, 32'd0);
    chk("rst_read", rd0, 32'd0);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_fill(vecs[i].sel, vecs[i].addr, vecs[i].base, vecs[i].first, vecs[i].space, nv, nl);
      chk("vec_word_count", nv, 32);
      chk("vec_last_count", nl, 1);
      en0 = 1'b0; en1 = 1'b0; addr0 = 'x; addr1 = 'x;
      tick();
    end

    // back-to-back: second request presented in the first IDLE cycle
    run_fill(0, 16'h0040, 16'h0040, 2, 1, nv, nl);
    run_fill(0, 16'h0FE0, 16'h0FE0, 2, 1, nv2, nl2);
    chk("b2b_total_valids", nv + nv2, 64);
    chk("b2b_total_lasts", nl + nl2, 2);
    en0 = 1'b0;
    tick();

    // abort after the 10th word
    en0 = 1'b1; addr0 = 16'h0200; n = 0; cnt = 0;
    while (n < 10 && cnt < 100) begin
      tick(); cnt++;
      if (vld0) n++;
    end
    chk("abort_reached_10", n, 10);
    en0 = 1'b0; addr0 = 'x;
    tick();
    chk("abort_bram_en_drop", {31'd0, ben0}, 32'd0);
    chk("abort_busy", {31'd0, busy0}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (vld0 || last0 || ben0) cnt++;
      tick();
    end
    chk("abort_no_residue", cnt, 0);
    run_fill(0, 16'h0100, 16'h0100, 2, 1, nv, nl);
    chk("post_abort_words", nv, 32);
    en0 = 1'b0;
    tick();

    // asynchronous reset in the middle of a burst
    en0 = 1'b1; addr0 = 16'h0300; n = 0; cnt = 0;
    while (n < 5 && cnt < 100) begin
      tick(); cnt++;
      if (vld0) n++;
    end
    chk("reset_reached_5", n, 5);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, vld0}, 32'd0);
    chk("arst_last", {31'd0, last0}, 32'd0);
    chk("arst_busy", {31'd0, busy0}, 32'd0);
    chk("arst_bram_en", {31'd0, ben0}, 32'd0);
    chk("arst_bram_addr", {16'd0, baddr0}, 32'd0);
    chk("arst_read", rd0, 32'd0);
    en0 = 1'b0; addr0 = 'x;
    tick();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (vld0 || last0 || busy0 || ben0) cnt++;
    end
    chk("post_reset_quiet", cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_mem_burst_responder.md
Name: inst_mem_burst_responder

Overview:
- Memory-side responder for the instruction cache line-fill protocol (mem_addr/mem_enable in; mem_read/mem_read_valid/mem_last out).
- On a fill request it reads one full block (BLOCK_SIZE words) from a synchronous word-addressed instruction BRAM, offset 0 first.
- It streams the words back with a per-word valid strobe and flags the final word.
- Sits between the instruction cache and the instruction BRAM.

Parameters:
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, 16, word address width (one word per address).
- BLOCK_OFFSET_WIDTH, 5, log2 words per block; BLOCK_SIZE = 1 << BLOCK_OFFSET_WIDTH.
- BRAM_LATENCY, 1, BRAM read latency in cycles (>= 1).
- GAP_CYCLES, 0, idle cycles inserted between consecutive word issues (throttling; >= 0).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- mem_addr  input  ADDR_WIDTH  fill request address; only the upper bits are used, offset bits ignored.
- mem_enable  input  1  fill request; held high by the requester for the whole burst.
- mem_read  output  DATA_WIDTH  returned word; 0 when mem_read_valid = 0.
- mem_read_valid  output  1  mem_read holds a block word this cycle.
- mem_last  output  1  high with mem_read_valid on the final word (offset BLOCK_SIZE-1) only.
- busy  output  1  high in any state other than IDLE.
- bram_en  output  1  BRAM read enable.
- bram_addr  output  ADDR_WIDTH  BRAM read address.
- bram_dout  input  DATA_WIDTH  BRAM read data, valid BRAM_LATENCY cycles after bram_en.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. All state is updated on the rising clk edge.
- Reset values: state = IDLE; mem_read_valid, mem_last, bram_en, busy = 0; bram_addr = 0; mem_read = 0; issue counter = 0; gap counter = 0; pipeline flags cleared.
- IDLE:
  - If mem_enable = 1 at a clock edge, latch base = {mem_addr[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH], zeros}.
  - Clear the issue counter and go to ISSUE.
  - mem_addr is ignored whenever mem_enable = 0; it may be X.
- ISSUE:
  - Registered outputs bram_en = 1 and bram_addr = base + k for k = 0..BLOCK_SIZE-1.
  - Consecutive issues are separated by exactly GAP_CYCLES cycles with bram_en = 0.
  - bram_addr holds its last value during gaps.
  - After issuing k = BLOCK_SIZE-1, go to DRAIN.
  - The issue counter is BLOCK_OFFSET_WIDTH+1 bits wide; the address offset never wraps into the index bits.
- Return pipeline:
  - An issue flag and a last flag (set for k = BLOCK_SIZE-1) are delayed through a BRAM_LATENCY-stage shift register, aligned with bram_dout.
  - mem_read_valid = delayed issue flag; mem_last = delayed last flag; mem_read = bram_dout when valid, else 0.
- DRAIN: issues nothing. When the delayed last flag emerges (mem_last = 1), go to IDLE on that edge.
- Timing, GAP=0, LAT=1, mem_enable first high in cycle 0:
  - bram_en is high in cycles 1..32.
  - mem_read_valid is high in cycles 2..33; mem_last is high in cycle 33.
  - State is IDLE in cycle 34, when the requester has already dropped mem_enable.
- Back-to-back: a new request may be accepted in the first IDLE cycle; there is no dead cycle beyond that.
- Abort: if mem_enable = 0 at a clock edge while in ISSUE or DRAIN:
  - Go to IDLE and flush the pipeline flags.
  - No further mem_read_valid or mem_last pulses appear; bram_en drops the next cycle.
- Exactly BLOCK_SIZE valid pulses and exactly one mem_last per completed burst.
- Reset mid-burst: outputs return to reset values immediately (asynchronous); no residual valid after reset release.

Test Plan:
- Single fill, GAP=0, LAT=1:
  - Stimulus: BRAM word at address a preloaded with value a ^ 32'hA5A50000; mem_enable held with mem_addr=16'h1234.
  - Response: 32 valids carrying addresses 16'h1220..16'h123F in order; first valid 2 cycles after request; mem_last only on the 16'h123F word; busy returns to 0.
- Back-to-back fills:
  - Stimulus: request 16'h0040, drop mem_enable one cycle after mem_last, immediately request 16'h0FE0.
  - Response: second burst starts in the first IDLE cycle; 64 total valids; 2 mem_last pulses.
- Throttled, GAP_CYCLES=2, BRAM_LATENCY=2:
  - Response: valids spaced exactly 3 cycles apart; first valid 3 cycles after request; last valid 1 + 31*3 + 2 = 96 cycles after request; data correct.
- Abort:
  - Stimulus: drop mem_enable after the 10th valid.
  - Response: no further mem_read_valid/mem_last; bram_en low within 1 cycle; a next request to 16'h0100 completes normally with 32 words.
- Async reset mid-burst:
  - Stimulus: assert rst between clock edges at word 5.
  - Response: all outputs 0 without waiting for an edge; after release, mem_enable=0 keeps the block in IDLE with no spurious valid.
- Offset ignore:
  - Stimulus: mem_addr = 16'hFFFF.
  - Response: words from 16'hFFE0..16'hFFFF; mem_last on 16'hFFFF; no wrap to 16'h0000.
